// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the execute-stage branch resolution logic:
//   - funct3 encodings of the six RV32I conditional branches
//   - FSM state encoding of the redirect/flush sequencer
//   - reset value of every 2-bit bimodal counter (weakly not taken)
//   - helper that tells whether a funct3 is a real conditional branch
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [1:0] CTR_RESET = 2'b01;

  // 010 and 011 are not branches; they must never train or redirect.
  function automatic logic f3_is_branch(input logic [2:0] f3);
    logic legal;
    legal = 1'b0;
    case (f3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// ---------------------------------------------------------------------------
// bht_2bit
// Array of 2-bit saturating bimodal counters.
//   clk, rst  : clock and synchronous active-high reset (all entries -> 01)
//   rd_idx    : fetch-side lookup index
//   rd_ctr    : current counter at rd_idx (combinational, pre-update value)
//   wr_en     : train the counter at wr_idx on the next rising edge
//   wr_idx    : index of the resolved branch
//   wr_taken  : 1 = increment (sat. at 11), 0 = decrement (sat. at 00)
// ---------------------------------------------------------------------------
module bht_2bit
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDX-1:0] rd_idx,
  output logic [1:0]     rd_ctr,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic           wr_taken
);

  logic [1:0] ctr [ENTRIES];

  // The read is taken straight from the array, so a same-cycle write to the
  // same entry is only visible from the following cycle on.
  assign rd_ctr = ctr[rd_idx];

  // Counter storage with saturating training; reset puts every entry into
  // the weakly-not-taken state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      if (wr_taken && (ctr[wr_idx] != 2'b11)) begin
        ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
      end else if (!wr_taken && (ctr[wr_idx] != 2'b00)) begin
        ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves conditional branches in EX, trains the bimodal predictor and
// issues a registered redirect plus a multi-cycle flush on a mispredict.
//   clk, rst              : clock, synchronous active-high reset
//   ex_valid              : conditional branch present in EX
//   ex_funct3             : branch funct3
//   ex_pc, ex_target      : PC of the branch and its computed target
//   ex_pred_taken         : direction predicted at fetch
//   BrEq, BrLT            : comparator results
//   BrUn                  : unsigned-compare select to the comparator
//   if_pc                 : fetch PC for the prediction lookup
//   if_pred_taken         : prediction for if_pc (counter MSB)
//   redirect_valid        : one-cycle registered redirect pulse
//   redirect_pc           : corrected fetch PC, valid with redirect_valid
//   flush                 : registered kill of IF/ID/EX, FLUSH_CYCLES long
//   stat_branches         : (BRANCH_STATS_EN) resolved legal branches
//   stat_mispredicts      : (BRANCH_STATS_EN) mispredicted branches
// Optional feature macro: BRANCH_STATS_EN adds the two saturating counters.
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX   = $clog2(BHT_ENTRIES);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   next_cnt;

  logic               taken;
  logic               resolve;
  logic               mispredict;
  logic [31:0]        correct_pc;
  logic               next_redirect_valid;
  logic [31:0]        next_redirect_pc;
  logic               next_flush;

  logic [1:0]         rd_ctr;
  logic [IDX-1:0]     if_idx;
  logic [IDX-1:0]     ex_idx;
  logic               unused_bits;

  assign BrUn          = ex_funct3[1];
  assign if_idx        = if_pc[IDX+1:2];
  assign ex_idx        = ex_pc[IDX+1:2];
  assign if_pred_taken = rd_ctr[1];

  // Only the index bits of the fetch PC and the counter MSB matter here.
  assign unused_bits = ^{if_pc[1:0], if_pc[31:IDX+2], rd_ctr[0]};

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX     (IDX)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (resolve),
    .wr_idx   (ex_idx),
    .wr_taken (taken)
  );

  // State register; the visible outputs are also registered here from the
  // next-state decode so they come straight out of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
    end else begin
      state          <= next_state;
      cnt            <= next_cnt;
      redirect_valid <= next_redirect_valid;
      redirect_pc    <= next_redirect_pc;
      flush          <= next_flush;
    end
  end

  // Next-state logic: a mispredict in IDLE starts the sequence, REDIRECT is
  // the first flush cycle and FLUSH covers the remaining FLUSH_CYCLES-1.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (mispredict) begin
          next_state = REDIRECT;
        end
      end
      REDIRECT: begin
        if (FLUSH_CYCLES == 1) begin
          next_state = IDLE;
        end else begin
          next_state = FLUSH;
          next_cnt   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        next_cnt = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Branch decision, mispredict detection and the values the output flops
  // will take. Branches are only looked at while IDLE, so anything arriving
  // during a flush is ignored completely.
  always_comb begin
    taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:  taken = BrEq;
      F3_BNE:  taken = !BrEq;
      F3_BLT:  taken = BrLT;
      F3_BGE:  taken = !BrLT;
      F3_BLTU: taken = BrLT;
      F3_BGEU: taken = !BrLT;
      default: taken = 1'b0;
    endcase

    resolve    = ex_valid && (state == IDLE) && f3_is_branch(ex_funct3);
    mispredict = resolve && (taken != ex_pred_taken);
    correct_pc = taken ? ex_target : (ex_pc + 32'd4);

    next_redirect_valid = (next_state == REDIRECT);
    next_flush          = (next_state != IDLE);
    next_redirect_pc    = mispredict ? correct_pc : redirect_pc;
  end

`ifdef BRANCH_STATS_EN
  // Saturating event counters for resolved branches and mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (resolve && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Self-checking bench: directed scenarios followed by random traffic, all
// checked against a behavioural model of the branch unit. A second instance
// with FLUSH_CYCLES=4 is used for the flush-length and reset-abort cases.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int ENTRIES = 64;
  localparam int FC      = 2;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        BrEq;
  logic        BrLT;
  logic [31:0] if_pc;

  logic        br_un, pred, rv, fl;
  logic [31:0] rpc;
  logic        br_un4, pred4, rv4, fl4;
  logic [31:0] rpc4;
`ifdef BRANCH_STATS_EN
  logic [31:0] st_br, st_mp, st_br4, st_mp4;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_bht [ENTRIES];
  int          m_flush_left;
  logic        m_rv;
  logic [31:0] m_rpc;
  longint      m_branches;
  longint      m_mispredicts;

  branch_resolve_unit #(.BHT_ENTRIES(ENTRIES), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(br_un), .if_pc(if_pc),
    .if_pred_taken(pred), .redirect_valid(rv), .redirect_pc(rpc),
    .flush(fl)
`ifdef BRANCH_STATS_EN
    , .stat_branches(st_br), .stat_mispredicts(st_mp)
`endif
  );

  branch_resolve_unit #(.BHT_ENTRIES(ENTRIES), .FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(br_un4), .if_pc(if_pc),
    .if_pred_taken(pred4), .redirect_valid(rv4), .redirect_pc(rpc4),
    .flush(fl4)
`ifdef BRANCH_STATS_EN
    , .stat_branches(st_br4), .stat_mispredicts(st_mp4)
`endif
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bhtIndex(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit isBranch(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  // Branch outcome straight from the RV32I definitions.
  function automatic bit modelTaken(input logic [2:0] f3, input logic eq,
                                    input logic lt);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
    m_flush_left  = 0;
    m_rv          = 1'b0;
    m_rpc         = 32'd0;
    m_branches    = 0;
    m_mispredicts = 0;
  endtask

  // One clock cycle: drive inputs, check the combinational outputs, advance
  // the model at the edge and check the registered outputs just after it.
  task automatic applyStimulus(input logic v, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input logic pt, input logic eq, input logic lt,
                               input logic [31:0] ipc, input logic r);
    bit t;
    rst = r; ex_valid = v; ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pt; BrEq = eq; BrLT = lt; if_pc = ipc;
    #1;
    checkOutput("br_un", 32'(br_un), 32'(f3[1]));
    checkOutput("if_pred_taken", 32'(pred), 32'(m_bht[bhtIndex(ipc)] >= 2));
    @(posedge clk);
    if (r) begin
      modelReset();
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_rv = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (v && isBranch(f3)) begin
        t = modelTaken(f3, eq, lt);
        m_branches++;
        if (t) m_bht[bhtIndex(pc)] = (m_bht[bhtIndex(pc)] == 3) ? 3 : m_bht[bhtIndex(pc)] + 1;
        else   m_bht[bhtIndex(pc)] = (m_bht[bhtIndex(pc)] == 0) ? 0 : m_bht[bhtIndex(pc)] - 1;
        if (t != pt) begin
          m_mispredicts++;
          m_flush_left = FC;
          m_rv         = 1'b1;
          m_rpc        = t ? tgt : pc + 32'd4;
        end
      end
    end
    #1;
    checkOutput("redirect_valid", 32'(rv), 32'(m_rv));
    checkOutput("flush", 32'(fl), 32'(m_flush_left > 0));
    if (m_rv) checkOutput("redirect_pc", rpc, m_rpc);
`ifdef BRANCH_STATS_EN
    checkOutput("stat_branches", st_br, 32'(m_branches));
    checkOutput("stat_mispredicts", st_mp, 32'(m_mispredicts));
`endif
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // Main stimulus sequence
  initial begin
    int flushCount;
    int redirCount;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [2:0]  f3;
    bit          pt;

    modelReset();
    rst = 1'b1; ex_valid = 1'b0; ex_funct3 = 3'b000; ex_pc = 32'd0;
    ex_target = 32'd0; ex_pred_taken = 1'b0; BrEq = 1'b0; BrLT = 1'b0;
    if_pc = 32'd0;

    $display("[TB] reset");
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1);
    checkOutput("reset_redirect_pc", rpc, 32'd0);
    checkOutput("reset_flush", 32'(fl), 32'd0);
    checkOutput("reset_redirect_valid", 32'(rv), 32'd0);

    $display("[TB] BEQ mispredict, flush length");
    applyStimulus(1'b1, 3'b000, 32'h100, 32'h180, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0);
    checkOutput("beq_redirect_valid", 32'(rv), 32'd1);
    checkOutput("beq_redirect_pc", rpc, 32'h180);
    flushCount = int'(fl);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      flushCount += int'(fl);
    end
    checkOutput("beq_flush_len", 32'(flushCount), 32'd2);

    $display("[TB] BNE not-taken wraps fall-through PC");
    applyStimulus(1'b1, 3'b001, 32'hFFFF_FFFC, 32'h1000, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("bne_wrap_pc", rpc, 32'h0000_0000);
    idleCycle();
    idleCycle();

    $display("[TB] BLT training at 0x200");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'b100, 32'h200, 32'h300, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
      checkOutput("blt_no_redirect", 32'(rv), 32'd0);
    end
    #1;
    checkOutput("blt_pred_after", 32'(pred), 32'd1);

    $display("[TB] non-branch funct3 and BrUn decode");
    applyStimulus(1'b1, 3'b010, 32'h400, 32'h500, 1'b1, 1'b0, 1'b0, 32'h400, 1'b0);
    checkOutput("f3_010_no_redirect", 32'(rv), 32'd0);
    applyStimulus(1'b1, 3'b011, 32'h400, 32'h500, 1'b1, 1'b0, 1'b0, 32'h400, 1'b0);
    applyStimulus(1'b1, 3'b111, 32'h404, 32'h500, 1'b1, 1'b0, 1'b0, 32'h404, 1'b0);
    applyStimulus(1'b1, 3'b101, 32'h408, 32'h500, 1'b0, 1'b0, 1'b1, 32'h408, 1'b0);
    idleCycle();

    $display("[TB] branches during flush are ignored");
    redirCount = 0;
    applyStimulus(1'b1, 3'b000, 32'h600, 32'h700, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0);
    redirCount += int'(rv);
    applyStimulus(1'b1, 3'b000, 32'h300, 32'h900, 1'b0, 1'b1, 1'b0, 32'h300, 1'b0);
    redirCount += int'(rv);
    applyStimulus(1'b1, 3'b001, 32'h304, 32'h900, 1'b1, 1'b1, 1'b0, 32'h304, 1'b0);
    redirCount += int'(rv);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h300 + 32'(4 * i), 1'b0);
      redirCount += int'(rv);
    end
    checkOutput("flush_ignore_redirects", 32'(redirCount), 32'd1);

    $display("[TB] FLUSH_CYCLES=4 length and reset abort");
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 3'b000, 32'h800, 32'h880, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("f4_redirect_valid", 32'(rv4), 32'd1);
    checkOutput("f4_redirect_pc", rpc4, 32'h880);
    flushCount = int'(fl4);
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      flushCount += int'(fl4);
    end
    checkOutput("f4_flush_len", 32'(flushCount), 32'd4);
    applyStimulus(1'b1, 3'b000, 32'h800, 32'h880, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    idleCycle();
    checkOutput("f4_in_flush", 32'(fl4), 32'd1);
    checkOutput("f4_in_flush_no_redirect", 32'(rv4), 32'd0);
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("f4_abort_flush", 32'(fl4), 32'd0);
    checkOutput("f4_abort_redirect", 32'(rv4), 32'd0);
`ifdef BRANCH_STATS_EN
    checkOutput("f4_abort_stat_branches", st_br4, 32'd0);
    checkOutput("f4_abort_stat_mispredicts", st_mp4, 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      if_pc = 32'(i * 36);
      #1;
      checkOutput("f4_abort_pred", 32'(pred4), 32'd0);
    end
    // A fresh correct branch must resolve straight away after the abort.
    applyStimulus(1'b1, 3'b000, 32'h800, 32'h880, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("f4_idle_after_abort", 32'(fl4), 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFF_FFFC;
      else                           pc = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 3) == 0) ipc = pc;
      else                           ipc = 32'($urandom_range(0, 127)) << 2;
      f3 = 3'($urandom_range(0, 7));
      pt = ($urandom_range(0, 1) == 0) ? (m_bht[bhtIndex(pc)] >= 2) : 1'($urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), f3, pc, $urandom & 32'hFFFF_FFFC,
                    pt, 1'($urandom), 1'($urandom), ipc,
                    ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the branch comparator outputs (BrEq, BrLT) in the single-issue RV32I core.
- Decodes funct3 into BrUn for the comparator, then decides whether the branch is taken.
- Compares the outcome with the fetch-time prediction and trains a 2-bit bimodal branch history table (BHT).
- On a mispredict, issues a registered PC redirect and a multi-cycle pipeline flush.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.
- FLUSH_CYCLES, 2, total cycles flush stays high per mispredict; at least 1.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  conditional branch present in EX this cycle
- ex_funct3  in  3  branch funct3
- ex_pc  in  32  PC of the EX branch
- ex_target  in  32  computed branch target (pc+imm)
- ex_pred_taken  in  1  prediction carried from fetch
- BrEq  in  1  from comparator
- BrLT  in  1  from comparator
- BrUn  out  1  to comparator; combinational, equals ex_funct3[1]
- if_pc  in  32  fetch PC for the prediction lookup
- if_pred_taken  out  1  combinational prediction, equals bit 1 of BHT[if_pc index]
- redirect_valid  out  1  registered, one-cycle pulse
- redirect_pc  out  32  registered, valid while redirect_valid is high
- flush  out  1  registered; kill IF/ID/EX contents

Behaviour:
- Index is pc[IDX+1:2], where IDX = log2(BHT_ENTRIES).
- Taken decode by funct3:
  - 000 BEQ: BrEq
  - 001 BNE: !BrEq
  - 100 BLT: BrLT
  - 101 BGE: !BrLT
  - 110 BLTU: BrLT
  - 111 BGEU: !BrLT
  - 010/011: not taken, no BHT update, never a mispredict.
- A branch resolves only when ex_valid=1 and the state is IDLE. While flushing, ex_valid is ignored entirely (no update, no redirect).
- On resolve, the BHT entry for ex_pc is updated at the next edge:
  - taken: increment, saturating at 11
  - not taken: decrement, saturating at 00
- Read-before-write: if if_pc and ex_pc map to the same index in the same cycle, if_pred_taken reflects the old counter value.
- Mispredict is taken != ex_pred_taken. The correct PC is ex_target if taken, else ex_pc+4 (32-bit, wraps modulo 2^32).
- FSM:
  - IDLE: resolve. On mispredict, go to REDIRECT. Otherwise stay in IDLE.
  - REDIRECT: redirect_valid=1, redirect_pc=correct PC, flush=1. If FLUSH_CYCLES=1, go to IDLE; else go to FLUSH with cnt=FLUSH_CYCLES-1.
  - FLUSH: flush=1 and redirect_valid=0. Decrement cnt; leave for IDLE on the cycle after cnt reaches 1.
  - Latency: the mispredict cycle N produces redirect_valid and flush at cycle N+1. flush stays high for exactly FLUSH_CYCLES cycles.
- Reset:
  - Outputs: redirect_valid=0, redirect_pc=0, flush=0.
  - State: IDLE, cnt=0.
  - Every BHT entry: 01 (weakly not taken).
  - Reset asserted mid-flush aborts it; the next cycle is IDLE with flush=0.
- Correct predictions produce no redirect and no flush. Back-to-back correct branches resolve every cycle.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds two outputs:
  - stat_branches (32): resolved valid branches with legal funct3
  - stat_mispredicts (32): mispredicts
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package branch_pkg holds:
  - funct3 localparams F3_BEQ/BNE/BLT/BGE/BLTU/BGEU
  - the FSM state encoding (IDLE, REDIRECT, FLUSH)
  - the 2-bit counter reset constant 2'b01
- One sub-module: bht_2bit, the counter array holding read port, write port and saturating update logic.

Test Plan:
- Reset, then BEQ at ex_pc=0x100, BrEq=1, ex_pred_taken=0, ex_target=0x180 -> cycle+1: redirect_valid=1, redirect_pc=0x180; flush high exactly 2 cycles.
- BNE at ex_pc=0xFFFFFFFC, BrEq=1, ex_pred_taken=1 -> redirect_pc=0x00000000 (wrap).
- Three BLT resolves taken at ex_pc=0x200 with matching prediction -> no redirect; if_pc=0x200 reads counter 01->10->11->11; if_pred_taken=1 after the first update.
- ex_funct3=010 with ex_valid=1 -> BrUn=1, no update, no redirect; BGEU -> BrUn=1; BGE -> BrUn=0.
- Mispredict followed by ex_valid=1 mispredicting branches during both flush cycles -> ignored; exactly one redirect; BHT unchanged for those PCs.
- rst asserted in the first FLUSH cycle (FLUSH_CYCLES=4) -> next cycle flush=0, state IDLE, if_pred_taken=0 for all PCs; with BRANCH_STATS_EN defined, counters read 0.
